// File: rtl/spi_slave_burst.sv
// SPI slave front-end for the single-port RAM: deserialises DATA_W+2 bit command words, serialises read data.
// Optional macro SPI_SLAVE_BURST_EN allows several words per SS_n frame; undefined means one word per frame.
`timescale 1ns/1ps
module spi_slave_burst #(
  parameter int DATA_W      = 8,
  parameter int TX_WAIT_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              rd_pending
);

  localparam int WORD_W = DATA_W + 2;
  localparam int CNT_W  = $clog2(WORD_W + 1);
  localparam int WAIT_W = (TX_WAIT_MAX > 1) ? $clog2(TX_WAIT_MAX) : 1;

`ifdef SPI_SLAVE_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [DATA_W:0]     r_rx_shift;
  logic [DATA_W-1:0]   r_tx_shift;
  logic                r_miso;
  logic [WORD_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_frame_err;
  logic                r_rd_pending;

  logic                w_last_bit;
  logic                w_tx_last;
  logic                w_wait_done;
  logic [WORD_W-1:0]   w_word;
  state_t              w_after_word;

  assign w_last_bit  = (r_bit_cnt == CNT_W'(WORD_W - 1));
  assign w_tx_last   = (r_bit_cnt == CNT_W'(DATA_W));
  assign w_wait_done = (r_wait_cnt == WAIT_W'(TX_WAIT_MAX - 1));
  assign w_word      = {r_rx_shift, MOSI};
  // Completed writes, read addresses and shift-outs either chain into the next word or park in DONE.
  assign w_after_word = (BURST_EN && !SS_n) ? CHK_CMD : DONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_rx_shift   <= '0;
      r_tx_shift   <= '0;
      r_miso       <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_rd_pending <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_miso    <= 1'b0;
          r_bit_cnt <= '0;
          if (!SS_n) r_state <= CHK_CMD;
        end
        CHK_CMD: begin
          if (SS_n) begin
            r_state     <= IDLE;
            r_frame_err <= 1'b1;
          end else begin
            r_rx_shift <= {r_rx_shift[DATA_W-1:0], MOSI};
            r_bit_cnt  <= CNT_W'(1);
            if (!MOSI)             r_state <= WRITE;
            else if (r_rd_pending) r_state <= READ_DATA;
            else                   r_state <= READ_ADD;
          end
        end
        WRITE, READ_ADD, READ_DATA: begin
          // The last bit wins over a simultaneous SS_n release: the word still counts.
          if (w_last_bit) begin
            r_rx_data  <= w_word;
            r_rx_valid <= 1'b1;
            case (r_state)
              READ_DATA: begin
                r_state    <= TX_WAIT;
                r_wait_cnt <= '0;
              end
              READ_ADD: begin
                r_rd_pending <= 1'b1;
                r_state      <= w_after_word;
              end
              default: r_state <= w_after_word;
            endcase
          end else if (SS_n) begin
            r_state     <= IDLE;
            r_frame_err <= 1'b1;
          end else begin
            r_rx_shift <= {r_rx_shift[DATA_W-1:0], MOSI};
            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
          end
        end
        TX_WAIT: begin
          if (SS_n) begin
            r_state      <= IDLE;
            r_frame_err  <= 1'b1;
            r_rd_pending <= 1'b0;
            r_miso       <= 1'b0;
          end else if (tx_valid) begin
            r_miso     <= tx_data[DATA_W-1];
            r_tx_shift <= tx_data << 1;
            r_bit_cnt  <= CNT_W'(1);
            r_state    <= TX_SHIFT;
          end else if (w_wait_done) begin
            r_state      <= DONE;
            r_frame_err  <= 1'b1;
            r_rd_pending <= 1'b0;
            r_miso       <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        TX_SHIFT: begin
          if (w_tx_last) begin
            r_miso       <= 1'b0;
            r_rd_pending <= 1'b0;
            r_state      <= w_after_word;
          end else if (SS_n) begin
            r_state      <= IDLE;
            r_frame_err  <= 1'b1;
            r_rd_pending <= 1'b0;
            r_miso       <= 1'b0;
          end else begin
            r_miso     <= r_tx_shift[DATA_W-1];
            r_tx_shift <= r_tx_shift << 1;
            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_miso <= 1'b0;
          if (SS_n) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MISO       = r_miso;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign rd_pending = r_rd_pending;

endmodule

// File: tb/tb_spi_slave_burst.sv
// Scoreboard bench for spi_slave_burst (DATA_W=8, TX_WAIT_MAX=16): directed frames, queued expectations.
`timescale 1ns/1ps
module tb_spi_slave_burst;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       frame_err;
  logic       rd_pending;

  int n_checks = 0;
  int n_err    = 0;

  logic [9:0] exp_rx_q[$];
  int         exp_err_cnt = 0;

  spi_slave_burst #(.DATA_W(8), .TX_WAIT_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .frame_err(frame_err), .rd_pending(rd_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every rx_valid / frame_err pulse against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rx_valid) begin
        n_checks++;
        if (exp_rx_q.size() == 0) begin
          n_err++;
          $display("FAIL rx_unexpected: got rx_data=%0h expected no rx_valid", rx_data);
        end else begin
          logic [9:0] e;
          e = exp_rx_q.pop_front();
          if (rx_data !== e) begin
            n_err++;
            $display("FAIL rx_data: got %0h expected %0h", rx_data, e);
          end else begin
            $display("rx word %0h at %0t", rx_data, $time);
          end
        end
      end
      if (frame_err) begin
        n_checks++;
        if (exp_err_cnt == 0) begin
          n_err++;
          $display("FAIL frame_err_unexpected: got 1 expected 0 at %0t", $time);
        end else begin
          exp_err_cnt--;
          $display("frame_err pulse at %0t", $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic frame_begin();
    @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
    @(negedge clk); SS_n = 1'b1;
    @(negedge clk); SS_n = 1'b0;
  endtask

  task automatic shift_word(input logic [9:0] w, input int nbits, input bit raise_last);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      MOSI = w[9-i];
      if (raise_last && i == nbits - 1) SS_n = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] exp_b;
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", MISO, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rd_pending", rd_pending, 0);
    rst_n = 1'b1;

    // Write address word
    exp_rx_q.push_back(10'h0A5);
    frame_begin(); shift_word(10'h0A5, 10, 1'b1);
    @(negedge clk);
    check("wr_rd_pending", rd_pending, 0);

    // Read address word
    exp_rx_q.push_back(10'h203);
    frame_begin(); shift_word(10'h203, 10, 1'b1);
    @(negedge clk);
    check("rdadd_rd_pending", rd_pending, 1);

    // Read data word, tx_valid three cycles into TX_WAIT
    exp_rx_q.push_back(10'h3F0);
    frame_begin(); shift_word(10'h3F0, 10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("txwait_miso", MISO, 0);
    check("txwait_rd_pending", rd_pending, 1);
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'hC3;
    exp_b = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      if (i == 7) begin tx_valid = 1'b0; tx_data = 8'h00; end
      check($sformatf("miso_bit%0d", i), MISO, exp_b[i]);
      if (i == 0) SS_n = 1'b1;
    end
    @(negedge clk);
    check("tx_end_miso", MISO, 0);
    check("tx_end_rd_pending", rd_pending, 0);

    // Abort after 6 of 10 bits
    exp_err_cnt++;
    frame_begin(); shift_word(10'h155, 6, 1'b0);
    @(negedge clk); SS_n = 1'b1;
    @(negedge clk);
    check("abort_frame_err", frame_err, 1);
    @(negedge clk);
    check("abort_rx_data_hold", rx_data, 10'h3F0);
    check("abort_rd_pending", rd_pending, 0);

    // Read timeout
    exp_rx_q.push_back(10'h2AA);
    frame_begin(); shift_word(10'h2AA, 10, 1'b1);
    exp_rx_q.push_back(10'h300);
    exp_err_cnt++;
    frame_begin(); shift_word(10'h300, 10, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check($sformatf("timeout_err_c%0d", k), frame_err, (k == 17) ? 1 : 0);
      check($sformatf("timeout_miso_c%0d", k), MISO, 0);
    end
    SS_n = 1'b1;
    @(negedge clk);
    check("timeout_rd_pending", rd_pending, 0);

    // Two words in one frame
    exp_rx_q.push_back(10'h0A5);
`ifdef SPI_SLAVE_BURST_EN
    exp_rx_q.push_back(10'h17E);
`endif
    frame_begin(); shift_word(10'h0A5, 10, 1'b0); shift_word(10'h17E, 10, 1'b1);
    repeat (2) @(negedge clk);
`ifdef SPI_SLAVE_BURST_EN
    check("burst_rx_data", rx_data, 10'h17E);
`else
    check("single_rx_data", rx_data, 10'h0A5);
`endif

    // Reset in the middle of TX_SHIFT
    exp_rx_q.push_back(10'h201);
    frame_begin(); shift_word(10'h201, 10, 1'b1);
    exp_rx_q.push_back(10'h3FF);
    frame_begin(); shift_word(10'h3FF, 10, 1'b0);
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk); tx_valid = 1'b0;
    check("pre_rst_miso", MISO, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_miso", MISO, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_frame_err", frame_err, 0);
    check("mid_rst_rd_pending", rd_pending, 0);
    exp_rx_q.push_back(10'h0C3);
    frame_begin(); shift_word(10'h0C3, 10, 1'b1);
    repeat (4) @(negedge clk);
    check("post_rst_rx_data", rx_data, 10'h0C3);

    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("err_queue_drained", exp_err_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_burst.md
Name: spi_slave_burst

Overview:
- Parametrised next-generation SPI slave front-end for the single-port RAM subsystem; clk doubles as the SPI serial clock.
- Deserialises command words of width DATA_W+2 from MOSI onto rx_data/rx_valid for the RAM.
- Serialises RAM read data from tx_data onto MISO.
- Compared with the previous slave it adds generic data width, frame-abort detection, a bounded wait for read data, and optional multi-word bursts within one SS_n frame.

Parameters:
- DATA_W, 8, RAM data/address width; a word is DATA_W+2 bits, with cmd in bits [DATA_W+1:DATA_W].
- TX_WAIT_MAX, 16, maximum cycles spent in TX_WAIT for tx_valid before a read is abandoned (must be >= 1).

Ports:
- clk  in  1  serial clock and system clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- rx_data  out  DATA_W+2  last complete received word.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- tx_data  in  DATA_W  read data from RAM.
- tx_valid  in  1  tx_data valid; sampled only in TX_WAIT.
- frame_err  out  1  one-cycle pulse; frame aborted mid-word or read timed out.
- rd_pending  out  1  a read address has been sent and its read-data command is awaited.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; MISO=0, rx_valid=0, rx_data=0, frame_err=0, rd_pending=0; bit counter, wait counter and tx shift register all cleared. Reset overrides any operation in progress.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE.
- IDLE: SS_n=0 -> CHK_CMD. MISO=0. Bit counter cleared.
- CHK_CMD:
  - MOSI is word bit DATA_W+1 and is shifted into the receive register; bit count becomes 1.
  - MOSI=0 -> WRITE; MOSI=1 and rd_pending=0 -> READ_ADD; MOSI=1 and rd_pending=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA:
  - Shift MOSI in each cycle until DATA_W+2 bits are received.
  - On the cycle the last bit is sampled: rx_data <= the full word, and rx_valid=1 on the following cycle for exactly one cycle.
  - rx_data holds its value until the next complete word; it is not cleared in IDLE.
- After a word completes:
  - READ_ADD word: rd_pending <= 1; next state is DONE or CHK_CMD (see burst).
  - READ_DATA word: next state is TX_WAIT.
  - WRITE word: next state is DONE or CHK_CMD (see burst).
- TX_WAIT:
  - tx_valid=1 -> latch tx_data and go to TX_SHIFT.
  - MISO = tx_data[DATA_W-1] on the cycle after tx_valid is sampled high.
  - If the wait counter reaches TX_WAIT_MAX without tx_valid: frame_err pulses, rd_pending <= 0, go to DONE, MISO=0.
- TX_SHIFT:
  - MISO presents the latched bits MSB first, one per cycle, for DATA_W cycles total. tx_data changes after latching are ignored.
  - After the last bit: MISO=0, rd_pending <= 0, go to DONE or CHK_CMD (see burst).
- DONE: hold with MISO=0 until SS_n=1, then go to IDLE.
- SS_n=1 mid-operation:
  - Applies in any state other than IDLE or DONE, before the word or the shift-out completes.
  - Go to IDLE next cycle; the partial word is discarded (no rx_valid, rx_data unchanged); frame_err pulses one cycle.
  - rd_pending is unchanged, except that an abort during TX_WAIT or TX_SHIFT clears it.
- Simultaneous last bit and SS_n=1: the word is complete, rx_valid pulses, and there is no frame_err.
- The second cmd bit is not decoded by the slave; it is forwarded in rx_data unchanged.

Optional Feature:
- Macro: SPI_SLAVE_BURST_EN.
- Defined: after a completed write word, read-address word or TX_SHIFT, if SS_n is still 0 the next state is CHK_CMD. Consecutive words in one frame each produce their own rx_valid. rd_pending routes successive reads exactly as in single-word mode.
- Undefined: those completions go to DONE. Further MOSI bits in the frame are ignored and produce no rx_valid or frame_err. One word per SS_n frame.

Test Plan (DATA_W=8, TX_WAIT_MAX=16):
- Write address: SS_n low, send 10'b00_1010_0101, then SS_n high → rx_data=10'h0A5, one rx_valid pulse, frame_err=0.
- Read pair:
  - Frame 1 sends 10'b10_0000_0011 → rd_pending=1.
  - Frame 2 sends 10'b11_xxxx_xxxx; tx_valid=1 with tx_data=8'hC3 three cycles later → MISO=1,1,0,0,0,0,1,1 starting one cycle after tx_valid; rd_pending returns to 0.
- Abort: SS_n high after 6 of 10 bits → no rx_valid, rx_data unchanged, frame_err=1 for one cycle, state IDLE.
- Timeout: send a read-data word and never assert tx_valid → frame_err pulses after 16 cycles in TX_WAIT, MISO stays 0, rd_pending=0.
- Burst with SPI_SLAVE_BURST_EN defined: two write words 10'h0A5 and 10'h17E in one frame → two rx_valid pulses 10 cycles apart. Without the macro: only the first pulse, and the second word is ignored.
- Reset mid-TX_SHIFT: rst_n low for one edge → all outputs 0, state IDLE, and the next frame decodes correctly.
